add_mul_mix_seq: RTL and testbench

Sequential, parametrised successor to the fixed 4-bit add-multiply-mix datapath. The block computes Result = (a + b) × (c + d) on W-bit unsigned operands. It accepts one operand set per transaction over a valid/ready handshake, then multiplies with an iterative shift-add engine. It sits between the operand staging registers and the result bus of the arithmetic cluster, and replaces the flat combinational implementation where area matters more than latency.

---
 rtl/add_mul_mix_seq.sv | 111 +++++++++++
 tb/tb_add_mul_mix_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/add_mul_mix_seq.sv
// rtl/add_mul_mix_seq.sv - (a+b)*(c+d) via iterative shift-add multiplier; optional ADD_MUL_MIX_SAT_EN saturates result
module add_mul_mix_seq #(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [W-1:0]     c,
   input  logic [W-1:0]     d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   result,
   output logic             ovf,
   output logic             busy
);

   localparam int PW = 2*W + 2;
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W);

   typedef enum logic [1:0] {IDLE, SUM, MUL, DONE} state_t;

   state_t          state;
   logic [W-1:0]    a_r, b_r, c_r, d_r;
   logic [PW-1:0]   mcand, acc;
   logic [W:0]      mplier;
   logic [CW-1:0]   cnt;

   logic [W:0]      s1, s2;
   logic [PW-1:0]   acc_nxt;
   logic            ovf_nxt;
   logic [2*W-1:0]  res_nxt;

   always_comb begin
      s1      = {1'b0, a_r} + {1'b0, b_r};
      s2      = {1'b0, c_r} + {1'b0, d_r};
      acc_nxt = mplier[0] ? (acc + mcand) : acc;
      ovf_nxt = |acc_nxt[PW-1:2*W];
`ifdef ADD_MUL_MIX_SAT_EN
      res_nxt = ovf_nxt ? {(2*W){1'b1}} : acc_nxt[2*W-1:0];
`else
      res_nxt = acc_nxt[2*W-1:0];
`endif
   end

   // result/ovf are captured from the final accumulate so out_valid rises on the last MUL edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         a_r       <= '0;
         b_r       <= '0;
         c_r       <= '0;
         d_r       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  c_r      <= c;
                  d_r      <= d;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SUM;
               end
            end
            SUM: begin
               mcand  <= {{(W+1){1'b0}}, s1};
               mplier <= s2;
               acc    <= '0;
               cnt    <= '0;
               state  <= MUL;
            end
            MUL: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  result    <= res_nxt;
                  ovf       <= ovf_nxt;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add_mul_mix_seq.sv
// tb/tb_add_mul_mix_seq.sv - self-checking bench for add_mul_mix_seq against a plain-arithmetic product model
module tb_add_mul_mix_seq;
   parameter int W = 4;
   localparam int RW = 2*W;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, out_valid, out_ready, ovf, busy;
   logic [W-1:0]  a, b, c, d;
   logic [RW-1:0] result;
   int            n_cmp = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   add_mul_mix_seq #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .ovf(ovf), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint model_res(input longint p);
      longint m;
      m = longint'(1) << RW;
      if (p < m) return p;
`ifdef ADD_MUL_MIX_SAT_EN
      return m - 1;
`else
      return p % m;
`endif
   endfunction

   task automatic run(input int ta, input int tb, input int tc, input int td, input int hold);
      longint p, m, exp_r;
      int w, lat;
      m  = longint'(1) << RW;
      ta = ta & ((1 << W) - 1);
      tb = tb & ((1 << W) - 1);
      tc = tc & ((1 << W) - 1);
      td = td & ((1 << W) - 1);
      p     = longint'(ta + tb) * longint'(tc + td);
      exp_r = model_res(p);
      a = W'(ta); b = W'(tb); c = W'(tc); d = W'(td);
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin tick(); w++; end
      chk("in_ready_idle", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("busy_sum", busy, 1);
      chk("in_ready_busy", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 50) begin tick(); lat++; end
      chk("latency", lat, W + 2);
      chk("result", result, exp_r);
      chk("ovf", ovf, (p >= m) ? 1 : 0);
      chk("busy_done", busy, 0);
      chk("in_ready_done", in_ready, 0);
      if (hold > 0) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
         for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, exp_r);
            chk("bp_in_ready", in_ready, 0);
         end
         out_ready = 1'b1;
      end
      tick();
      chk("out_valid_drop", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
      chk("result_kept", result, exp_r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; c = '0; d = '0;
      tick(); tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      tick();

      run(3, 2, 1, 4, 0);
      run((1 << W) - 1, (1 << W) - 1, (1 << W) - 1, (1 << W) - 1, 0);
      run(0, 0, 9, 6, 0);
      run(5, 6, 7, 8, 5);
      run(2, 3, 4, 1, 0);

      // abort on the third MUL cycle: accept edge, SUM edge, two MUL edges, reset edge
      a = W'(7); b = W'(7); c = W'(7); d = W'(7);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_ovf", ovf, 0);
      rst_n = 1'b1;
      begin
         int seen = 0;
         for (int i = 0; i < W + 6; i++) begin
            tick();
            if (out_valid) seen++;
         end
         chk("mid_rst_no_pulse", seen, 0);
      end
      run(1, 1, 1, 1, 0);

      for (int k = 0; k < 20; k++)
         run(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, 3)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
